// File: rtl/gate_sweep_checker_v.sv
// Exhaustive sweep engine: drives every N_IN-bit vector into a combinational gate,
// holds it HOLD clocks, and checks the output against a reduction reference.
// Optional STOP_ON_FAIL_EN: end the sweep on the first mismatching sample.
module gate_sweep_checker_v #(
  parameter int N_IN = 4,
  parameter int HOLD = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_mode,
  input  logic            i_dut_f,
  output logic [N_IN-1:0] o_vec,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_first_fail
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int EW = N_IN + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [EW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;

  logic ref_f, sample, mismatch, stop;

  always_comb begin
    case (mode_q)
      3'd0:    ref_f = &vec_q;
      3'd2:    ref_f = |vec_q;
      3'd3:    ref_f = ~|vec_q;
      3'd4:    ref_f = ^vec_q;
      3'd5:    ref_f = ~^vec_q;
      default: ref_f = ~&vec_q;
    endcase
  end

  assign sample   = (cnt_q == HOLD_LAST);
  assign mismatch = sample && (i_dut_f != ref_f);
`ifdef STOP_ON_FAIL_EN
  assign stop = (&vec_q) || mismatch;
`else
  assign stop = &vec_q;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          mode_d  = i_mode;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end
      S_RUN: begin
        if (sample) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + EW'(1);
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = vec_q;
            end
          end
          if (stop) begin
            // pass must reflect the count including this final sample
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  assign o_vec        = vec_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_cnt    = err_q;
  assign o_fail_valid = fv_q;
  assign o_first_fail = ff_q;

endmodule

// File: tb/tb_gate_sweep_checker_v.sv
// Directed bench: instance A (N_IN=4, HOLD=2) drives a NAND gate, instance B
// (N_IN=2, HOLD=1) drives a NOR gate.
module tb_gate_sweep_checker_v;

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b;
  logic [2:0] mode_a, mode_b;

  logic [3:0] vec_a, ff_a;
  logic [4:0] err_a;
  logic       busy_a, done_a, pass_a, fv_a, dut_f_a;
  logic [1:0] vec_b, ff_b;
  logic [2:0] err_b;
  logic       busy_b, done_b, pass_b, fv_b, dut_f_b;

  assign dut_f_a = ~&vec_a;
  assign dut_f_b = ~|vec_b;

  gate_sweep_checker_v #(.N_IN(4), .HOLD(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mode(mode_a), .i_dut_f(dut_f_a),
    .o_vec(vec_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_cnt(err_a), .o_fail_valid(fv_a), .o_first_fail(ff_a));

  gate_sweep_checker_v #(.N_IN(2), .HOLD(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(mode_b), .i_dut_f(dut_f_b),
    .o_vec(vec_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_cnt(err_b), .o_fail_valid(fv_b), .o_first_fail(ff_b));

  int errors = 0;
  int checks = 0;

  task automatic run_a(input logic [2:0] m, output int cyc, output bit got);
    @(negedge clk); start_a = 1'b1; mode_a = m;
    @(negedge clk); start_a = 1'b0;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_a) begin got = 1'b1; break; end
      if (busy_a) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 3'd0; mode_b = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a} !== 17'd0) begin
      errors++; $display("FAIL reset_a got=%h want=0", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a});
    end
    checks++;
    if ({vec_b, busy_b, done_b, pass_b, err_b, fv_b, ff_b} !== 11'd0) begin
      errors++; $display("FAIL reset_b got=%h want=0", {vec_b, busy_b, done_b, pass_b, err_b, fv_b, ff_b});
    end
  endtask

  task automatic test_pass_nand();
    int c;
    bit got;
    @(negedge clk); start_a = 1'b1; mode_a = 3'd1;
    @(negedge clk); start_a = 1'b0;
    c = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_a) begin got = 1'b1; break; end
      checks++;
      if (vec_a !== 4'(c / 2)) begin
        errors++; $display("FAIL nand_vec cyc=%0d got=%0d want=%0d", c, vec_a, c / 2);
      end
      if (busy_a) c++;
      @(negedge clk);
    end
    checks++;
    if (!got || c != 32) begin errors++; $display("FAIL nand_busy got=%0d done=%0b want=32", c, got); end
    checks++;
    if ({pass_a, err_a, fv_a, vec_a} !== {1'b1, 5'd0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL nand_result pass=%0b err=%0d fv=%0b vec=%0d want 1,0,0,0", pass_a, err_a, fv_a, vec_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || pass_a !== 1'b1) begin
      errors++; $display("FAIL nand_done_pulse done=%0b pass=%0b want 0,1", done_a, pass_a);
    end
  endtask

  task automatic test_modes();
    logic [2:0] modes [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    int         full  [6] = '{16, 2, 14, 7, 9, 0};
    int         first [6] = '{0, 0, 1, 0, 1, 0};
    int cyc, exp_err, exp_cyc;
    bit got;
    for (int t = 0; t < 6; t++) begin
      run_a(modes[t], cyc, got);
      exp_err = (STOP && full[t] > 0) ? 1 : full[t];
      exp_cyc = (STOP && full[t] > 0) ? (first[t] + 1) * 2 : 32;
      checks++;
      if (!got || cyc != exp_cyc) begin
        errors++; $display("FAIL mode%0d_busy got=%0d done=%0b want=%0d", modes[t], cyc, got, exp_cyc);
      end
      checks++;
      if (err_a !== 5'(exp_err)) begin
        errors++; $display("FAIL mode%0d_err got=%0d want=%0d", modes[t], err_a, exp_err);
      end
      checks++;
      if (ff_a !== 4'(first[t]) || fv_a !== (full[t] > 0)) begin
        errors++; $display("FAIL mode%0d_first got=%0d/%0b want=%0d/%0b", modes[t], ff_a, fv_a, first[t], full[t] > 0);
      end
      checks++;
      if (pass_a !== (full[t] == 0) || vec_a !== 4'd0) begin
        errors++; $display("FAIL mode%0d_pass got=%0b vec=%0d want=%0b vec=0", modes[t], pass_a, vec_a, full[t] == 0);
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL mode%0d_pulse got=%0b want=0", modes[t], done_a); end
    end
  endtask

  task automatic test_hold1();
    int c;
    bit got;
    @(negedge clk); start_b = 1'b1; mode_b = 3'd3;
    @(negedge clk); start_b = 1'b0;
    c = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_b) begin got = 1'b1; break; end
      checks++;
      if (vec_b !== 2'(c)) begin errors++; $display("FAIL hold1_vec cyc=%0d got=%0d want=%0d", c, vec_b, c); end
      if (busy_b) c++;
      @(negedge clk);
    end
    checks++;
    if (!got || c != 4) begin errors++; $display("FAIL hold1_busy got=%0d done=%0b want=4", c, got); end
    checks++;
    if ({pass_b, err_b, vec_b} !== {1'b1, 3'd0, 2'd0}) begin
      errors++; $display("FAIL hold1_result pass=%0b err=%0d vec=%0d want 1,0,0", pass_b, err_b, vec_b);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit got, saw_done;
    @(negedge clk); start_a = 1'b1; mode_a = STOP ? 3'd1 : 3'd0;
    @(negedge clk); start_a = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin saw_done |= done_a; @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a} !== 17'd0) begin
      errors++; $display("FAIL midrst_zero got=%h want=0", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a});
    end
    repeat (40) begin saw_done |= done_a | busy_a; @(negedge clk); end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midrst_done got=1 want=0"); end
    run_a(3'd1, cyc, got);
    checks++;
    if (!got || cyc != 32 || pass_a !== 1'b1) begin
      errors++; $display("FAIL midrst_rerun got=%0d pass=%0b want=32 pass=1", cyc, pass_a);
    end
  endtask

  task automatic test_start_ignored();
    int c;
    bit got;
    @(negedge clk); start_a = 1'b1; mode_a = 3'd1;
    @(negedge clk); start_a = 1'b0;
    c = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_a) begin got = 1'b1; break; end
      if (busy_a) c++;
      start_a = (c == 5 || c == 20);
      mode_a  = (c >= 5) ? 3'd0 : 3'd1;
      @(negedge clk);
    end
    start_a = 1'b0;
    checks++;
    if (!got || c != 32) begin errors++; $display("FAIL ign_busy got=%0d done=%0b want=32", c, got); end
    checks++;
    if (pass_a !== 1'b1 || err_a !== 5'd0) begin
      errors++; $display("FAIL ign_result pass=%0b err=%0d want 1,0", pass_a, err_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL ign_queued busy=%0b want=0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_pass_nand();
    test_modes();
    test_hold1();
    test_reset_midrun();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
